// File: rtl/matrix_stream_loader_pkg.sv
// Shared types and defaults for the matrix multiplier front end (package matrix_pkg).
// Used by the stream loader and its element counter.
package matrix_pkg;

    localparam int DEFAULT_N      = 64;
    localparam int DEFAULT_DATA_W = 64;
    localparam int ELEMS          = DEFAULT_N * DEFAULT_N;

    typedef logic [DEFAULT_DATA_W-1:0] elem_t;

    typedef enum logic [1:0] {
        LOAD_A    = 2'd0,
        LOAD_B    = 2'd1,
        START     = 2'd2,
        WAIT_DONE = 2'd3
    } loader_state_t;

endpackage

// File: rtl/matrix_stream_loader_elem_counter.sv
// Row-major element index generator for an N x N matrix: flat idx plus row/col,
// with a wrap strobe on the advance that leaves the last element.
module matrix_elem_counter
    import matrix_pkg::*;
#(
    parameter int N = DEFAULT_N,
    localparam int IDX_W = $clog2(N * N),
    localparam int RC_W  = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             adv,
    output logic [IDX_W-1:0] idx,
    output logic [RC_W-1:0]  row,
    output logic [RC_W-1:0]  col,
    output logic             wrap
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N * N - 1);
    localparam logic [RC_W-1:0]  LAST_COL = RC_W'(N - 1);

    logic [IDX_W-1:0] idx_q, idx_d;
    logic [RC_W-1:0]  row_q, row_d;
    logic [RC_W-1:0]  col_q, col_d;
    logic             at_last;

    assign at_last = (idx_q == LAST_IDX);

    // row/col are tracked alongside idx so no divider is needed for non-power-of-two N
    always_comb begin
        idx_d = idx_q;
        row_d = row_q;
        col_d = col_q;
        if (clr || (adv && at_last)) begin
            idx_d = '0;
            row_d = '0;
            col_d = '0;
        end else if (adv) begin
            idx_d = idx_q + IDX_W'(1);
            if (col_q == LAST_COL) begin
                col_d = '0;
                row_d = row_q + RC_W'(1);
            end else begin
                col_d = col_q + RC_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q <= '0;
            row_q <= '0;
            col_q <= '0;
        end else begin
            idx_q <= idx_d;
            row_q <= row_d;
            col_q <= col_d;
        end
    end

    assign idx  = idx_q;
    assign row  = row_q;
    assign col  = col_q;
    assign wrap = adv && at_last;

endmodule

// File: rtl/matrix_stream_loader.sv
// Streams A then B (row-major) into register buffers, kicks the multiplier and waits for done.
// Optional in_last framing check with sticky load_err: define MATRIX_LOADER_FRAMING_EN.
module matrix_stream_loader
    import matrix_pkg::*;
#(
    parameter int N      = DEFAULT_N,
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic [DATA_W-1:0] matrix_A [N][N],
    output logic [DATA_W-1:0] matrix_B [N][N],
    output logic              mm_start,
    input  logic              mm_done,
    output logic              busy,
    output logic [CNT_W-1:0]  job_cnt
`ifdef MATRIX_LOADER_FRAMING_EN
    ,
    output logic              load_err
`endif
);

    localparam int IDX_W = $clog2(N * N);
    localparam int RC_W  = $clog2(N);

    // Handshake: a beat transfers on a rising edge where in_valid && in_ready;
    // in_ready depends only on state, and in_data need not be held while in_ready is low.

    loader_state_t     state_q, state_d;
    logic              mm_start_q, mm_start_d;
    logic [CNT_W-1:0]  job_cnt_q, job_cnt_d;
    logic [DATA_W-1:0] mat_a_q [N][N];
    logic [DATA_W-1:0] mat_a_d [N][N];
    logic [DATA_W-1:0] mat_b_q [N][N];
    logic [DATA_W-1:0] mat_b_d [N][N];

    logic              beat;
    logic              we_a;
    logic              we_b;
    logic              cnt_clr;
    logic [IDX_W-1:0]  cnt_idx;
    logic [RC_W-1:0]   cnt_row;
    logic [RC_W-1:0]   cnt_col;
    logic              cnt_wrap;
    logic              idx_unused;

    matrix_elem_counter #(
        .N(N)
    ) u_elem_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .adv   (beat),
        .idx   (cnt_idx),
        .row   (cnt_row),
        .col   (cnt_col),
        .wrap  (cnt_wrap)
    );

    // The flat index is exported for the result drain; the loader addresses by row/col.
    assign idx_unused = ^cnt_idx;

    assign in_ready = (state_q == LOAD_A) || (state_q == LOAD_B);
    assign busy     = (state_q == START) || (state_q == WAIT_DONE);
    assign beat     = in_valid && in_ready;

`ifdef MATRIX_LOADER_FRAMING_EN
    logic load_err_q, load_err_d;
    logic b_last_beat;

    assign b_last_beat = (state_q == LOAD_B) && cnt_wrap;
`else
    logic in_last_unused;

    assign in_last_unused = in_last;
`endif

    always_comb begin
        state_d    = state_q;
        mm_start_d = 1'b0;
        job_cnt_d  = job_cnt_q;
        we_a       = 1'b0;
        we_b       = 1'b0;
        cnt_clr    = 1'b0;
`ifdef MATRIX_LOADER_FRAMING_EN
        load_err_d = load_err_q;
`endif
        case (state_q)
            LOAD_A: begin
                if (beat) begin
                    we_a = 1'b1;
                    if (cnt_wrap) state_d = LOAD_B;
                end
            end
            LOAD_B: begin
                if (beat) begin
                    we_b = 1'b1;
                    if (cnt_wrap) begin
                        state_d    = START;
                        mm_start_d = 1'b1;
                    end
                end
            end
            START: begin
                state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                // mm_done is only looked at here, so a level left over from the last job is harmless
                if (mm_done) begin
                    state_d   = LOAD_A;
                    job_cnt_d = job_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = LOAD_A;
            end
        endcase
`ifdef MATRIX_LOADER_FRAMING_EN
        // An early in_last resynchronises to the start of A; the partial job never starts.
        if (beat && in_last && !b_last_beat) begin
            load_err_d = 1'b1;
            cnt_clr    = 1'b1;
            state_d    = LOAD_A;
            mm_start_d = 1'b0;
            we_a       = 1'b0;
            we_b       = 1'b0;
        end else if (b_last_beat && !in_last) begin
            load_err_d = 1'b1;
        end
`endif
    end

    always_comb begin
        mat_a_d = mat_a_q;
        mat_b_d = mat_b_q;
        if (we_a) mat_a_d[cnt_row][cnt_col] = in_data;
        if (we_b) mat_b_d[cnt_row][cnt_col] = in_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= LOAD_A;
            mm_start_q <= 1'b0;
            job_cnt_q  <= '0;
            mat_a_q    <= '{default: '0};
            mat_b_q    <= '{default: '0};
        end else begin
            state_q    <= state_d;
            mm_start_q <= mm_start_d;
            job_cnt_q  <= job_cnt_d;
            mat_a_q    <= mat_a_d;
            mat_b_q    <= mat_b_d;
        end
    end

`ifdef MATRIX_LOADER_FRAMING_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_err_q <= 1'b0;
        end else begin
            load_err_q <= load_err_d;
        end
    end

    assign load_err = load_err_q;
`endif

    assign matrix_A = mat_a_q;
    assign matrix_B = mat_b_q;
    assign mm_start = mm_start_q;
    assign job_cnt  = job_cnt_q;

endmodule
